// File: rtl/mem_uart_controller.sv
// Purpose : MEM-stage load/store engine for RAM1 and the UART, which share the ram1Data bus.
// Latency : RAM read RAM_WAIT+1 cycles to done; RAM write RAM_WAIT+2; UART accesses wait on data_ready/tbre/tsre.
// Backpr. : busy stalls the upstream pipeline from the request cycle until the DONE cycle.
// Option  : define MEMCTRL_TIMEOUT_EN to bound the UART write-drain wait by TIMEOUT_CYCLES (sticky timeout_err).
module mem_uart_controller #(
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
    parameter int          RAM_WAIT       = 1,
    parameter int          TIMEOUT_CYCLES = 1023
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        ram1OE,
    output logic        ram1WE,
    output logic        ram1EN,
    output logic [17:0] ram1Addr,
    inout  wire  [15:0] ram1Data,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre,
    output logic        rdn,
    output logic        wrn,
    output logic        timeout_err
);

    typedef enum logic [3:0] {
        IDLE,
        RAM_RD,
        RAM_WR,
        RAM_WR_HOLD,
        UART_STAT,
        UART_RD_WAIT,
        UART_RD,
        UART_WR_SETUP,
        UART_WR_WAIT_TBRE,
        UART_WR_WAIT_TSRE,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  wait_cnt;
    logic        ram_last;
    logic        bus_oe;
    logic [15:0] bus_dat;
    logic        to_hit;

    // Last cycle of a RAM strobe window
    assign ram_last = (wait_cnt == 3'(RAM_WAIT - 1));

`ifdef MEMCTRL_TIMEOUT_EN
    logic [9:0] to_cnt;
    logic       to_err_q;
    logic       in_wr_wait;

    assign in_wr_wait  = (state == UART_WR_WAIT_TBRE) || (state == UART_WR_WAIT_TSRE);
    assign to_hit      = in_wr_wait && (to_cnt == 10'(TIMEOUT_CYCLES - 1));
    assign timeout_err = to_err_q;

    // Drain-wait counter spans both wait states; error flag is sticky until reset
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            to_cnt   <= 10'd0;
            to_err_q <= 1'b0;
        end else begin
            if (state == UART_WR_SETUP) begin
                to_cnt <= 10'd0;
            end else if (in_wr_wait) begin
                to_cnt <= to_cnt + 10'd1;
            end
            if (to_hit) begin
                to_err_q <= 1'b1;
            end
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register, strobe-window counter and read-data capture
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
            rdata    <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                wait_cnt <= 3'd0;
            end else if ((state == RAM_RD) || (state == RAM_WR)) begin
                wait_cnt <= wait_cnt + 3'd1;
            end
            case (state)
                RAM_RD:    if (ram_last) rdata <= ram1Data;
                UART_STAT: rdata <= {14'b0, data_ready, tbre & tsre};
                UART_RD:   rdata <= {8'b0, ram1Data[7:0]};
                default:   ;
            endcase
        end
    end

    // Next-state decode and strobe generation; strobes idle high outside their states
    always_comb begin
        state_nxt = state;
        ram1EN    = 1'b1;
        ram1OE    = 1'b1;
        ram1WE    = 1'b1;
        rdn       = 1'b1;
        wrn       = 1'b1;
        bus_oe    = 1'b0;
        bus_dat   = wdata;
        case (state)
            IDLE: begin
                if (req_wr) begin
                    if (addr == UART_STAT_ADDR)      state_nxt = DONE;
                    else if (addr == UART_DATA_ADDR) state_nxt = UART_WR_SETUP;
                    else                             state_nxt = RAM_WR;
                end else if (req_rd) begin
                    if (addr == UART_STAT_ADDR)      state_nxt = UART_STAT;
                    else if (addr == UART_DATA_ADDR) state_nxt = UART_RD_WAIT;
                    else                             state_nxt = RAM_RD;
                end
            end
            RAM_RD: begin
                ram1EN = 1'b0;
                ram1OE = 1'b0;
                if (ram_last) state_nxt = DONE;
            end
            RAM_WR: begin
                ram1EN = 1'b0;
                ram1WE = 1'b0;
                bus_oe = 1'b1;
                if (ram_last) state_nxt = RAM_WR_HOLD;
            end
            RAM_WR_HOLD: begin
                ram1EN    = 1'b0;
                bus_oe    = 1'b1;
                state_nxt = DONE;
            end
            UART_STAT: state_nxt = DONE;
            UART_RD_WAIT: begin
                if (data_ready) state_nxt = UART_RD;
            end
            UART_RD: begin
                rdn       = 1'b0;
                state_nxt = DONE;
            end
            UART_WR_SETUP: begin
                bus_oe    = 1'b1;
                bus_dat   = {8'b0, wdata[7:0]};
                wrn       = 1'b0;
                state_nxt = UART_WR_WAIT_TBRE;
            end
            UART_WR_WAIT_TBRE: begin
                // keep data on the bus past the wrn rising edge
                bus_oe  = 1'b1;
                bus_dat = {8'b0, wdata[7:0]};
                if (to_hit)    state_nxt = DONE;
                else if (tbre) state_nxt = UART_WR_WAIT_TSRE;
            end
            UART_WR_WAIT_TSRE: begin
                bus_oe  = 1'b1;
                bus_dat = {8'b0, wdata[7:0]};
                if (to_hit || tsre) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ram1Data = bus_oe ? bus_dat : 16'hzzzz;
    assign ram1Addr = ((state == RAM_RD) || (state == RAM_WR) || (state == RAM_WR_HOLD))
                      ? {2'b00, addr} : 18'h00000;
    assign done     = (state == DONE);
    // busy drops in DONE so the pipeline advances and releases the request
    assign busy     = ((state != IDLE) && (state != DONE)) ||
                      ((state == IDLE) && (req_rd || req_wr));

endmodule

// File: tb/tb_mem_uart_controller.sv
module tb_mem_uart_controller;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_rd, req_wr;
    logic [15:0] addr, wdata;
    logic [15:0] rdata;
    logic        busy, done;
    logic        ram1OE, ram1WE, ram1EN;
    logic [17:0] ram1Addr;
    wire  [15:0] ram1Data;
    logic        data_ready, tbre, tsre;
    logic        rdn, wrn, timeout_err;

    mem_uart_controller #(.TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK), .RST(RST), .req_rd(req_rd), .req_wr(req_wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .ram1OE(ram1OE), .ram1WE(ram1WE),
        .ram1EN(ram1EN), .ram1Addr(ram1Addr), .ram1Data(ram1Data), .data_ready(data_ready),
        .tbre(tbre), .tsre(tsre), .rdn(rdn), .wrn(wrn), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    // RAM1 and UART bus models
    logic [15:0] mem [0:255];
    logic [15:0] uart_rx;
    assign ram1Data = (!ram1EN && !ram1OE) ? mem[ram1Addr[7:0]] :
                      (!rdn ? uart_rx : 16'hzzzz);

    always @(posedge CLK) begin
        if (RST && !ram1EN && !ram1WE) mem[ram1Addr[7:0]] <= ram1Data;
    end

    int          checks = 0;
    int          errors = 0;
    int          we_lo, oe_lo, rdn_lo, wrn_lo, busy_cnt;
    logic [17:0] we_addr;
    logic [15:0] tx_dat;
    logic        prev_done = 1'b0;

    typedef struct {
        logic        is_rd;
        logic [15:0] exp;
        int          tag;
    } exp_t;
    exp_t exp_q[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    // Strobe activity recorder
    always @(negedge CLK) begin
        if (!ram1WE) begin we_lo++; we_addr = ram1Addr; end
        if (!ram1OE) oe_lo++;
        if (!rdn) rdn_lo++;
        if (!wrn) begin wrn_lo++; tx_dat = ram1Data; end
        if (busy) busy_cnt++;
    end

    // Scoreboard monitor: every done pulse consumes one expected response
    always @(negedge CLK) begin
        if (RST && done) begin
            chk("done_busy_low", {31'b0, busy}, 32'd0);
            chk("done_one_cycle", {31'b0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done actual=1 required=0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_rd) chk($sformatf("rdata_tag%0d", e.tag), {16'b0, rdata}, {16'b0, e.exp});
            end
        end
        prev_done = done;
    end

    task automatic clr_cnt();
        we_lo = 0; oe_lo = 0; rdn_lo = 0; wrn_lo = 0; busy_cnt = 0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp, input int tag, output int lat);
        exp_t e;
        e.is_rd = rd & ~wr;
        e.exp   = exp;
        e.tag   = tag;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        clr_cnt();
        req_rd = rd; req_wr = wr; addr = a; wdata = d;
        @(negedge CLK);
        chk($sformatf("busy_in_req_tag%0d", tag), {31'b0, busy}, 32'd1);
        lat = 0;
        while (!done) begin
            if (lat == 200) begin
                checks++;
                errors++;
                $display("FAIL done_timeout_tag%0d actual=none required=done", tag);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                break;
            end
            @(negedge CLK);
            lat++;
        end
        chk($sformatf("busy_cycles_tag%0d", tag), busy_cnt, lat);
        @(posedge CLK);
        #1;
        req_rd = 1'b0; req_wr = 1'b0;
    endtask

    int lat;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        RST = 1'b0; req_rd = 1'b0; req_wr = 1'b0; addr = 16'h0; wdata = 16'h0;
        data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1; uart_rx = 16'hFF41;
        clr_cnt();
        #12;
        chk("rst_strobes", {27'b0, ram1EN, ram1OE, ram1WE, rdn, wrn}, 32'h1F);
        chk("rst_busy_done", {30'b0, busy, done}, 32'd0);
        chk("rst_rdata", {16'b0, rdata}, 32'd0);
        chk("rst_addr", {14'b0, ram1Addr}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        // RAM write then read
        access(1'b0, 1'b1, 16'h4000, 16'hBEEF, 16'h0, 1, lat);
        chk("wr_lat", lat, 3);
        chk("wr_we_cycles", we_lo, 1);
        chk("wr_addr", {14'b0, we_addr}, 32'h04000);
        access(1'b1, 1'b0, 16'h4000, 16'h0, 16'hBEEF, 2, lat);
        chk("rd_lat", lat, 2);
        chk("rd_oe_cycles", oe_lo, 1);

        // More RAM patterns, and rd+wr together acting as a write
        access(1'b0, 1'b1, 16'h0012, 16'h5A5A, 16'h0, 3, lat);
        access(1'b1, 1'b1, 16'h0055, 16'h1111, 16'h0, 4, lat);
        chk("rdwr_is_write", we_lo, 1);
        access(1'b1, 1'b0, 16'h0012, 16'h0, 16'h5A5A, 5, lat);
        access(1'b1, 1'b0, 16'h0055, 16'h0, 16'h1111, 6, lat);

        // Status reads
        data_ready = 1'b1; tbre = 1'b1; tsre = 1'b0;
        access(1'b1, 1'b0, 16'hBF01, 16'h0, 16'h0002, 7, lat);
        chk("stat_no_strobes", we_lo + oe_lo + rdn_lo + wrn_lo, 0);
        data_ready = 1'b0; tsre = 1'b1;
        access(1'b1, 1'b0, 16'hBF01, 16'h0, 16'h0001, 8, lat);

        // Write to status register is ignored
        access(1'b0, 1'b1, 16'hBF01, 16'hFFFF, 16'h0, 9, lat);
        chk("statwr_lat", lat, 1);
        chk("statwr_no_strobes", we_lo + oe_lo + rdn_lo + wrn_lo, 0);

        // UART read: data_ready low for 5 wait cycles
        data_ready = 1'b0;
        fork
            access(1'b1, 1'b0, 16'hBF00, 16'h0, 16'h0041, 10, lat);
            begin repeat (6) @(posedge CLK); #1 data_ready = 1'b1; end
        join
        chk("uart_rd_lat", lat, 7);
        chk("uart_rdn_cycles", rdn_lo, 1);
        data_ready = 1'b0;

        // UART write: tbre 3 cycles after wrn, tsre 2 later
        tbre = 1'b0; tsre = 1'b0;
        fork
            access(1'b0, 1'b1, 16'hBF00, 16'h1234, 16'h0, 11, lat);
            begin
                repeat (5) @(posedge CLK); #1 tbre = 1'b1;
                repeat (2) @(posedge CLK); #1 tsre = 1'b1;
            end
        join
        chk("uart_wr_lat", lat, 7);
        chk("uart_wrn_cycles", wrn_lo, 1);
        chk("uart_tx_data", {16'b0, tx_dat}, 32'h0034);

        // Reset asserted mid RAM write while WE is low
        @(posedge CLK);
        #1;
        req_wr = 1'b1; addr = 16'h4001; wdata = 16'h7777;
        @(posedge CLK);
        #2;
        chk("mid_we_low", {31'b0, ram1WE}, 32'd0);
        RST = 1'b0;
        #1;
        chk("mid_rst_strobes", {27'b0, ram1EN, ram1OE, ram1WE, rdn, wrn}, 32'h1F);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        req_wr = 1'b0;
        #1;
        chk("mid_rst_idle", {31'b0, busy}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        access(1'b1, 1'b0, 16'h4001, 16'h0, 16'h0000, 12, lat);
        chk("post_rst_rd_lat", lat, 2);

`ifdef MEMCTRL_TIMEOUT_EN
        chk("to_err_clear", {31'b0, timeout_err}, 32'd0);
        tbre = 1'b0; tsre = 1'b0;
        access(1'b0, 1'b1, 16'hBF00, 16'h00AA, 16'h0, 13, lat);
        chk("to_lat", lat, 10);
        chk("to_err_set", {31'b0, timeout_err}, 32'd1);
        repeat (3) @(negedge CLK);
        chk("to_err_sticky", {31'b0, timeout_err}, 32'd1);
`else
        chk("to_err_tied", {31'b0, timeout_err}, 32'd0);
`endif

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
